smm_intc: RTL

Interrupt controller for the soft microcontroller (smm) register bus. Aggregates NUM_SRC peripheral interrupt lines into the smm single INTERRUPT/INTERRUPT_ACK handshake. Provides memory-mapped pending, mask, edge-select, clear and vector registers. Sits on the smm bus beside the other register slaves, and its read data is OR-combined onto smm DIN.

---
 rtl/smm_intc_pkg.sv | 28 ++
 rtl/smm_intc_prio_enc.sv | 22 ++
 rtl/smm_intc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/smm_intc_pkg.sv
// Shared constants, state encoding and helpers for the smm interrupt controller.
package smm_intc_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_VEC_CLR = 2'd3;

    localparam int VEC_ACTIVE_BIT = 31;
    localparam int VEC_ID_LSB     = 0;
    localparam int VEC_ID_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } intc_state_e;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  be);
        logic [31:0] lane_mask;
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_val & ~lane_mask) | (wr_val & lane_mask);
    endfunction

endpackage

// File: rtl/smm_intc_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set request bit.
module smm_intc_prio_enc
    import smm_intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]  req,
    output logic [VEC_ID_W-1:0] id,
    output logic                valid
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        id    = 5'd0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            id    = req[i] ? 5'(i) : id;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/smm_intc.sv
// smm interrupt controller: pending/mask/edge-select/vector registers and request handshake FSM.
// Optional input synchronizer enabled by defining SMM_INTC_SYNC_EN.
module smm_intc
    import smm_intc_pkg::*;
#(
    parameter int          NUM_SRC      = 8,
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter logic [31:0] EDGE_DEFAULT = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    input  logic               CS,
    input  logic               RNW,
    input  logic [15:0]        ADDR,
    input  logic [3:0]         BE,
    input  logic [31:0]        WDATA,
    output logic [31:0]        RDATA,
    output logic               INTERRUPT,
    input  logic               INTERRUPT_ACK
);

    localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_SRC) - 32'd1);

    logic [31:0]         irq_s;
    logic [31:0]         irq_prev_r;
    logic [31:0]         pending_r;
    logic [31:0]         mask_r;
    logic [31:0]         edge_sel_r;
    logic [31:0]         rise_s;
    logic [31:0]         clr_s;
    logic [31:0]         edge_chg_s;
    logic [31:0]         pending_nxt_s;
    logic [31:0]         mask_wr_s;
    logic [31:0]         edge_wr_s;
    logic [31:0]         clr_wr_s;
    logic [31:0]         ack_clr_s;
    logic [31:0]         rd_val_s;
    logic [31:0]         rdata_r;
    logic [NUM_SRC-1:0]  eligible_s;
    logic [VEC_ID_W-1:0] prio_id_s;
    logic                prio_valid_s;
    logic                access_s;
    logic                wr_s;
    logic                rd_s;
    logic [1:0]          reg_sel_s;
    logic                unused_addr_s;

    intc_state_e         state_r;
    logic                interrupt_r;
    logic                vec_active_r;
    logic [VEC_ID_W-1:0] vec_id_r;

`ifdef SMM_INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_r;
    logic [NUM_SRC-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous peripheral lines.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= IRQ_SRC;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = 32'(sync2_r);
`else
    assign irq_s = 32'(IRQ_SRC);
`endif

    assign access_s      = CS & (ADDR[15:4] == BASE_ADDR[15:4]);
    assign wr_s          = access_s & ~RNW;
    assign rd_s          = access_s & RNW;
    assign reg_sel_s     = ADDR[3:2];
    assign unused_addr_s = ^ADDR[1:0];

    // Register write values, clear sources and next-pending computation.
    always_comb begin
        mask_wr_s  = be_merge(mask_r, WDATA, BE) & SRC_MASK;
        edge_wr_s  = be_merge(edge_sel_r, WDATA, BE) & SRC_MASK;
        clr_wr_s   = be_merge(32'h0000_0000, WDATA, BE) & SRC_MASK;
        rise_s     = irq_s & ~irq_prev_r;
        ack_clr_s  = ((state_r == ST_ASSERT) && INTERRUPT_ACK && edge_sel_r[vec_id_r])
                     ? (32'd1 << vec_id_r) : 32'h0000_0000;
        clr_s      = ((wr_s && (reg_sel_s == REG_VEC_CLR)) ? clr_wr_s : 32'h0000_0000) | ack_clr_s;
        edge_chg_s = (wr_s && (reg_sel_s == REG_EDGE)) ? (edge_wr_s ^ edge_sel_r) : 32'h0000_0000;
        // A new rising edge beats a clear in the same cycle; a mode change forces the bit low.
        pending_nxt_s = ~edge_chg_s & SRC_MASK &
                        ((edge_sel_r & (rise_s | (pending_r & ~clr_s))) | (~edge_sel_r & irq_s));
    end

    // Source status registers and software-visible configuration.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_prev_r <= 32'h0000_0000;
            pending_r  <= 32'h0000_0000;
            mask_r     <= 32'h0000_0000;
            edge_sel_r <= EDGE_DEFAULT & SRC_MASK;
        end else begin
            irq_prev_r <= irq_s;
            pending_r  <= pending_nxt_s;
            mask_r     <= (wr_s && (reg_sel_s == REG_MASK)) ? mask_wr_s : mask_r;
            edge_sel_r <= (wr_s && (reg_sel_s == REG_EDGE)) ? edge_wr_s : edge_sel_r;
        end
    end

    assign eligible_s = pending_r[NUM_SRC-1:0] & mask_r[NUM_SRC-1:0];

    smm_intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req   (eligible_s),
        .id    (prio_id_s),
        .valid (prio_valid_s)
    );

    // Request handshake: latch the winner, hold it until acked, then force one low cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            interrupt_r  <= 1'b0;
            vec_active_r <= 1'b0;
            vec_id_r     <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (prio_valid_s) begin
                        state_r      <= ST_ASSERT;
                        interrupt_r  <= 1'b1;
                        vec_active_r <= 1'b1;
                        vec_id_r     <= prio_id_s;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    if (INTERRUPT_ACK) begin
                        state_r      <= ST_GAP;
                        interrupt_r  <= 1'b0;
                        vec_active_r <= 1'b0;
                    end else begin
                        state_r      <= ST_ASSERT;
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    interrupt_r  <= 1'b0;
                    vec_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Read data multiplexer.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_PENDING: rd_val_s = pending_r;
            REG_MASK:    rd_val_s = mask_r;
            REG_EDGE:    rd_val_s = edge_sel_r;
            REG_VEC_CLR: begin
                rd_val_s[VEC_ACTIVE_BIT]                    = vec_active_r;
                rd_val_s[VEC_ID_LSB +: VEC_ID_W]            = vec_id_r;
            end
            default:     rd_val_s = 32'h0000_0000;
        endcase
    end

    // Registered read data, zero whenever no read was accepted the previous cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata_r <= 32'h0000_0000;
        end else begin
            rdata_r <= rd_s ? rd_val_s : 32'h0000_0000;
        end
    end

    assign RDATA     = rdata_r;
    assign INTERRUPT = interrupt_r;

endmodule
